store_write_buffer: RTL and testbench

Memory-side write buffer that accepts byte-masked word stores from the cache/data-controller side and drains them to data memory in order. It holds up to 2**DEPTH_LOG2 pending stores. It provides byte-wise store-to-load forwarding so the read path sees pending writes before they reach memory. It sits between the store path of the memory unit and the data memory write port, decoupling store issue from memory availability.

---
 rtl/store_write_buffer_if.sv | 51 +++++
 rtl/store_write_buffer.sv | 124 ++++++++++++
 tb/tb_store_write_buffer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/store_write_buffer_if.sv
// Store write buffer bus bundle: store push channel, memory drain channel,
// load forwarding lookup and occupancy status.
interface store_write_buffer_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int DEPTH_LOG2    = 2
);
    // Store push channel from the cache / data-controller side
    logic                      push_valid;
    logic                      push_ready;
    logic [ADDRESS_WIDTH-1:0]  push_address;
    logic [DATA_WIDTH-1:0]     push_data;
    logic [DATA_WIDTH/8-1:0]   push_mask;

    // Drain channel toward the data memory write port
    logic                      mem_write_enable;
    logic [ADDRESS_WIDTH-1:0]  mem_address;
    logic [DATA_WIDTH-1:0]     mem_write_data;
    logic [DATA_WIDTH/8-1:0]   mem_byte_mask;
    logic                      mem_ready;

    // Load forwarding lookup
    logic [ADDRESS_WIDTH-1:0]  lookup_address;
    logic                      lookup_hit;
    logic [DATA_WIDTH-1:0]     lookup_data;
    logic [DATA_WIDTH/8-1:0]   lookup_mask;

    // Occupancy status
    logic                      empty;
    logic [DEPTH_LOG2:0]       count;

    // View of the buffer itself
    modport slave (
        input  push_valid, push_address, push_data, push_mask,
        input  mem_ready, lookup_address,
        output push_ready,
        output mem_write_enable, mem_address, mem_write_data, mem_byte_mask,
        output lookup_hit, lookup_data, lookup_mask,
        output empty, count
    );

    // View of the surrounding memory unit (store path, memory, load path)
    modport master (
        output push_valid, push_address, push_data, push_mask,
        output mem_ready, lookup_address,
        input  push_ready,
        input  mem_write_enable, mem_address, mem_write_data, mem_byte_mask,
        input  lookup_hit, lookup_data, lookup_mask,
        input  empty, count
    );
endinterface

// File: rtl/store_write_buffer.sv
// Store write buffer: in-order circular queue of byte-masked word stores that
// drains to data memory, coalesces into the youngest non-head entry and
// forwards pending bytes to the load path (youngest matching entry wins).
module store_write_buffer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int DEPTH_LOG2    = 2
) (
    input  logic                clk,
    input  logic                rst,
    store_write_buffer_if.slave bus
);
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   COUNT_TWO  = (DEPTH_LOG2 + 1)'(2);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [ADDRESS_WIDTH-1:0] r_entryAddr [DEPTH];
    logic [DATA_WIDTH-1:0]    r_entryData [DEPTH];
    logic [MASK_WIDTH-1:0]    r_entryMask [DEPTH];

    logic [DEPTH_LOG2-1:0]    r_head;
    logic [DEPTH_LOG2-1:0]    r_tail;
    logic [DEPTH_LOG2:0]      r_count;

    logic                     w_full;
    logic                     w_empty;
    logic [DEPTH_LOG2-1:0]    w_youngest;
    logic                     w_pushFire;
    logic                     w_pushNonzero;
    logic                     w_coalesce;
    logic                     w_alloc;
    logic                     w_retire;

    logic [DEPTH_LOG2-1:0]    w_ageIdx;
    logic [DATA_WIDTH-1:0]    w_lookupData;
    logic [MASK_WIDTH-1:0]    w_lookupMask;

    // Occupancy comes purely from the registered count, so push_ready has no
    // combinational path from mem_ready; a full buffer refuses a push even
    // when the head leaves in the same cycle.
    assign w_full        = (r_count == FULL_COUNT);
    assign w_empty       = (r_count == '0);
    assign w_youngest    = r_tail - PTR_ONE;
    assign w_pushFire    = bus.push_valid && !w_full;
    assign w_pushNonzero = |bus.push_mask;

    // Coalescing needs at least two entries so the youngest is never the head,
    // which keeps the word currently offered to memory stable.
    assign w_coalesce = w_pushFire && w_pushNonzero && (r_count >= COUNT_TWO) &&
                        (r_entryAddr[w_youngest] == bus.push_address);
    assign w_alloc    = w_pushFire && w_pushNonzero && !w_coalesce;
    assign w_retire   = !w_empty && bus.mem_ready;

    // Head/tail pointers and entry count; reset wins over push and retire
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_retire) begin
                r_head <= r_head + PTR_ONE;
            end
            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage: allocate a fresh entry at tail or merge bytes into the youngest
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_entryAddr[r_tail] <= bus.push_address;
            r_entryData[r_tail] <= bus.push_data;
            r_entryMask[r_tail] <= bus.push_mask;
        end else if (w_coalesce) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (bus.push_mask[b]) begin
                    r_entryData[w_youngest][b*8 +: 8] <= bus.push_data[b*8 +: 8];
                end
            end
            r_entryMask[w_youngest] <= r_entryMask[w_youngest] | bus.push_mask;
        end
    end

    // Forwarding merge walks entries oldest to youngest so later stores overwrite earlier bytes
    always_comb begin
        w_lookupData = '0;
        w_lookupMask = '0;
        w_ageIdx     = r_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_ageIdx = r_head + DEPTH_LOG2'(k);
            if (((DEPTH_LOG2 + 1)'(k) < r_count) &&
                (r_entryAddr[w_ageIdx] == bus.lookup_address)) begin
                for (int b = 0; b < MASK_WIDTH; b++) begin
                    if (r_entryMask[w_ageIdx][b]) begin
                        w_lookupData[b*8 +: 8] = r_entryData[w_ageIdx][b*8 +: 8];
                        w_lookupMask[b]        = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.push_ready       = !w_full;
    assign bus.mem_write_enable = !w_empty;
    assign bus.mem_address      = r_entryAddr[r_head];
    assign bus.mem_write_data   = r_entryData[r_head];
    assign bus.mem_byte_mask    = r_entryMask[r_head];
    assign bus.lookup_hit       = |w_lookupMask;
    assign bus.lookup_data      = w_lookupData;
    assign bus.lookup_mask      = w_lookupMask;
    assign bus.empty            = w_empty;
    assign bus.count            = r_count;
endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: a queue model of pending stores acts as the
// scoreboard; accepted pushes go in, the head is compared against mem_* every
// cycle and popped when memory accepts it, and forwarding is checked each cycle.
module tb_store_write_buffer;
    localparam int DW = 32;
    localparam int AW = 30;
    localparam int DL = 2;
    localparam int DEPTH = 1 << DL;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [DW/8-1:0] mask;
    } entry_t;

    logic clk;
    logic rst;
    int   nChecks;
    int   nFail;
    entry_t sbQueue[$];

    store_write_buffer_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH_LOG2(DL)) bus ();

    store_write_buffer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH_LOG2(DL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [DW/8-1:0] mask);
        bus.push_valid   = valid;
        bus.push_address = addr;
        bus.push_data    = data;
        bus.push_mask    = mask;
    endtask

    function automatic void modelLookup(input logic [AW-1:0] addr,
                                        output logic [DW-1:0] fData, output logic [DW/8-1:0] fMask);
        fData = '0;
        fMask = '0;
        for (int i = 0; i < sbQueue.size(); i++) begin
            if (sbQueue[i].addr == addr) begin
                for (int b = 0; b < DW/8; b++) begin
                    if (sbQueue[i].mask[b]) begin
                        fData[b*8 +: 8] = sbQueue[i].data[b*8 +: 8];
                        fMask[b]        = 1'b1;
                    end
                end
            end
        end
    endfunction

    // One clock: compare outputs at the falling edge, then advance the model at the rising edge
    task automatic stepCycle();
        bit              accept;
        bit              retire;
        logic [AW-1:0]   pAddr;
        logic [DW-1:0]   pData;
        logic [DW/8-1:0] pMask;
        logic [DW-1:0]   fData;
        logic [DW/8-1:0] fMask;
        entry_t          e;
        int              last;
        @(negedge clk);
        checkOutput("count", 64'(bus.count), 64'(sbQueue.size()));
        checkOutput("empty", 64'(bus.empty), 64'(sbQueue.size() == 0));
        checkOutput("pushReady", 64'(bus.push_ready), 64'(sbQueue.size() < DEPTH));
        checkOutput("memWe", 64'(bus.mem_write_enable), 64'(sbQueue.size() != 0));
        if (sbQueue.size() != 0) begin
            checkOutput("memAddr", 64'(bus.mem_address), 64'(sbQueue[0].addr));
            checkOutput("memData", 64'(bus.mem_write_data), 64'(sbQueue[0].data));
            checkOutput("memMask", 64'(bus.mem_byte_mask), 64'(sbQueue[0].mask));
        end
        modelLookup(bus.lookup_address, fData, fMask);
        checkOutput("lookupHit", 64'(bus.lookup_hit), 64'(fMask != 0));
        checkOutput("lookupMask", 64'(bus.lookup_mask), 64'(fMask));
        checkOutput("lookupData", 64'(bus.lookup_data), 64'(fData));
        accept = bus.push_valid && (sbQueue.size() < DEPTH);
        retire = (sbQueue.size() != 0) && bus.mem_ready;
        pAddr  = bus.push_address;
        pData  = bus.push_data;
        pMask  = bus.push_mask;
        @(posedge clk);
        if (rst) begin
            sbQueue.delete();
        end else begin
            if (accept && pMask != 0) begin
                last = sbQueue.size() - 1;
                if (sbQueue.size() >= 2 && sbQueue[last].addr == pAddr) begin
                    e = sbQueue[last];
                    for (int b = 0; b < DW/8; b++) begin
                        if (pMask[b]) e.data[b*8 +: 8] = pData[b*8 +: 8];
                    end
                    e.mask = e.mask | pMask;
                    sbQueue[last] = e;
                end else begin
                    e.addr = pAddr;
                    e.data = pData;
                    e.mask = pMask;
                    sbQueue.push_back(e);
                end
            end
            if (retire) void'(sbQueue.pop_front());
        end
        #1;
    endtask

    task automatic drainAll();
        bus.mem_ready = 1'b1;
        applyStimulus(1'b0, '0, '0, '0);
        for (int n = 0; n < 4 * DEPTH && bus.empty !== 1'b1; n++) stepCycle();
        checkOutput("drainDone", 64'(bus.empty), 64'd1);
    endtask

    initial begin
        nChecks = 0;
        nFail   = 0;
        rst     = 1'b1;
        applyStimulus(1'b0, '0, '0, '0);
        bus.mem_ready      = 1'b0;
        bus.lookup_address = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sbQueue.delete();

        $display("[TB] reset state");
        checkOutput("rstCount", 64'(bus.count), 64'd0);
        checkOutput("rstEmpty", 64'(bus.empty), 64'd1);
        checkOutput("rstPushReady", 64'(bus.push_ready), 64'd1);
        checkOutput("rstMemWe", 64'(bus.mem_write_enable), 64'd0);
        checkOutput("rstLookupHit", 64'(bus.lookup_hit), 64'd0);
        checkOutput("rstLookupMask", 64'(bus.lookup_mask), 64'd0);
        checkOutput("rstLookupData", 64'(bus.lookup_data), 64'd0);

        $display("[TB] single push and retire");
        bus.mem_ready = 1'b1;
        applyStimulus(1'b1, 30'h10, 32'hDEADBEEF, 4'hF);
        stepCycle();
        applyStimulus(1'b0, '0, '0, '0);
        checkOutput("singleWe", 64'(bus.mem_write_enable), 64'd1);
        checkOutput("singleAddr", 64'(bus.mem_address), 64'h10);
        checkOutput("singleData", 64'(bus.mem_write_data), 64'hDEADBEEF);
        checkOutput("singleMask", 64'(bus.mem_byte_mask), 64'hF);
        stepCycle();
        checkOutput("singleEmpty", 64'(bus.empty), 64'd1);

        $display("[TB] fill, held push, full with simultaneous retire");
        bus.mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 30'(i), 32'h01010101 * 32'(i), 4'hF);
            stepCycle();
        end
        applyStimulus(1'b1, 30'h5, 32'h55555555, 4'hF);
        stepCycle();
        checkOutput("fullCount", 64'(bus.count), 64'd4);
        checkOutput("fullPushReady", 64'(bus.push_ready), 64'd0);
        bus.mem_ready = 1'b1;
        stepCycle();
        checkOutput("fullRetireCount", 64'(bus.count), 64'd3);
        checkOutput("fullRetireReady", 64'(bus.push_ready), 64'd1);
        stepCycle();
        checkOutput("pushAfterFullCount", 64'(bus.count), 64'd3);
        drainAll();

        $display("[TB] coalescing into youngest entry");
        bus.mem_ready = 1'b0;
        applyStimulus(1'b1, 30'h8, 32'h000000AA, 4'h1);
        stepCycle();
        applyStimulus(1'b1, 30'h9, 32'h11111111, 4'hF);
        stepCycle();
        applyStimulus(1'b1, 30'h9, 32'h0000BB00, 4'h2);
        stepCycle();
        applyStimulus(1'b0, '0, '0, '0);
        bus.lookup_address = 30'h9;
        #1;
        checkOutput("coalCount", 64'(bus.count), 64'd2);
        checkOutput("coalData", 64'(bus.lookup_data), 64'h1111BB11);
        checkOutput("coalMask", 64'(bus.lookup_mask), 64'hF);
        drainAll();

        $display("[TB] forwarding merge");
        bus.mem_ready = 1'b0;
        applyStimulus(1'b1, 30'h20, 32'h000000AA, 4'h1);
        stepCycle();
        applyStimulus(1'b1, 30'h20, 32'h0000CCDD, 4'h3);
        stepCycle();
        applyStimulus(1'b0, '0, '0, '0);
        bus.lookup_address = 30'h20;
        #1;
        checkOutput("fwdCount", 64'(bus.count), 64'd2);
        checkOutput("fwdHit", 64'(bus.lookup_hit), 64'd1);
        checkOutput("fwdMask", 64'(bus.lookup_mask), 64'h3);
        checkOutput("fwdData", 64'(bus.lookup_data), 64'h0000CCDD);
        bus.lookup_address = 30'h21;
        #1;
        checkOutput("fwdMissHit", 64'(bus.lookup_hit), 64'd0);
        checkOutput("fwdMissData", 64'(bus.lookup_data), 64'd0);
        drainAll();

        $display("[TB] reset mid-drain");
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 30'h30 + 30'(i), 32'hA0A0A0A0 + 32'(i), 4'hF);
            stepCycle();
        end
        applyStimulus(1'b0, '0, '0, '0);
        checkOutput("preRstCount", 64'(bus.count), 64'd3);
        bus.lookup_address = 30'h30;
        bus.mem_ready = 1'b1;
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("midRstCount", 64'(bus.count), 64'd0);
        checkOutput("midRstMemWe", 64'(bus.mem_write_enable), 64'd0);
        checkOutput("midRstHit", 64'(bus.lookup_hit), 64'd0);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 30'h40 + 30'($urandom_range(0, 3)),
                          32'($urandom), 4'($urandom_range(0, 15)));
            if (n < 200) bus.mem_ready = ($urandom_range(0, 2) == 0);
            else         bus.mem_ready = ($urandom_range(0, 3) != 0);
            bus.lookup_address = 30'h40 + 30'($urandom_range(0, 3));
            stepCycle();
        end
        drainAll();

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
